// File: rtl/cordic_sched.sv
// Round-robin front end for a shared, fixed-latency CORDIC pipeline.
// A {valid, tag} shadow pipeline runs alongside the CORDIC, so each result
// can be steered back to the requester that issued it. A result that its
// owner does not accept freezes the CORDIC and the shadow pipeline together,
// so results are never dropped and never reordered.
module cordic_sched #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 19,
    parameter int NREQ    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic        [NREQ-1:0]             req_valid,
    output logic        [NREQ-1:0]             req_ready,
    input  logic        [NREQ*WIDTH-1:0]       req_x,
    input  logic        [NREQ*WIDTH-1:0]       req_y,
    input  logic        [NREQ*WIDTH-1:0]       req_z,
    output logic        [NREQ-1:0]             rsp_valid,
    input  logic        [NREQ-1:0]             rsp_ready,
    output logic signed [WIDTH:0]              rsp_x,
    output logic signed [WIDTH:0]              rsp_y,
    output logic signed [WIDTH-1:0]            rsp_z,
    output logic                               cordic_en,
    output logic signed [WIDTH-1:0]            cordic_x0,
    output logic signed [WIDTH-1:0]            cordic_y0,
    output logic signed [WIDTH-1:0]            cordic_z0,
    input  logic signed [WIDTH:0]              cordic_x,
    input  logic signed [WIDTH:0]              cordic_y,
    input  logic signed [WIDTH-1:0]            cordic_z,
    output logic        [$clog2(LATENCY+1)-1:0] inflight
);

    localparam int TAG_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [LATENCY-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic               out_valid;
    logic [TAG_W-1:0]   out_tag;
    logic               grant_found;
    logic [TAG_W-1:0]   grant_idx;
    logic               xfer;
    logic               consume;

    assign out_valid = valid_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

    // The pipeline only advances when the result at its tail (if any) is taken;
    // reset forces it running so the flush is not blocked by a stalled result.
    assign cordic_en = reset | !(out_valid && !rsp_ready[out_tag]);
    assign xfer      = grant_found && cordic_en && !reset;
    assign consume   = out_valid && cordic_en && !reset;

    assign rsp_x    = cordic_x;
    assign rsp_y    = cordic_y;
    assign rsp_z    = cordic_z;
    assign inflight = inflight_q;

    // Round-robin search: first active requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[TAG_W'((int'(ptr_q) + k) % NREQ)]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Handshake decode, operand mux (zeros on bubbles) and result steering.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        cordic_x0 = '0;
        cordic_y0 = '0;
        cordic_z0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && grant_idx == TAG_W'(i)) begin
                req_ready[i] = 1'b1;
                cordic_x0    = $signed(req_x[i*WIDTH +: WIDTH]);
                cordic_y0    = $signed(req_y[i*WIDTH +: WIDTH]);
                cordic_z0    = $signed(req_z[i*WIDTH +: WIDTH]);
            end
            if (out_valid && !reset && out_tag == TAG_W'(i)) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    // Next-state for the arbiter pointer and the occupancy counter.
    always_comb begin
        ptr_d      = xfer ? grant_idx : ptr_q;
        inflight_d = inflight_q;
        case ({xfer, consume})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state: valid shadow pipeline, pointer and occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            ptr_q      <= TAG_W'(NREQ - 1);
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            if (cordic_en) begin
                for (int s = LATENCY - 1; s > 0; s--) begin
                    valid_q[s] <= valid_q[s-1];
                end
                valid_q[0] <= xfer;
            end
        end
    end

    // Tag shadow pipeline; contents only matter where the matching valid is set.
    always_ff @(posedge clk) begin
        if (cordic_en) begin
            for (int s = LATENCY - 1; s > 0; s--) begin
                tag_q[s] <= tag_q[s-1];
            end
            tag_q[0] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Randomized and directed bench for cordic_sched with a behavioural
// CORDIC pipeline stand-in and a queue-based scoreboard.
module tb_cordic_sched;

    localparam int W   = 16;
    localparam int LAT = 19;
    localparam int N   = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic        [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic        [N*W-1:0]     req_x, req_y, req_z;
    logic signed [W:0]         rsp_x, rsp_y, cordic_x, cordic_y;
    logic signed [W-1:0]       rsp_z, cordic_z, cordic_x0, cordic_y0, cordic_z0;
    logic                      cordic_en;
    logic [$clog2(LAT+1)-1:0]  inflight;

    cordic_sched #(.WIDTH(W), .LATENCY(LAT), .NREQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .cordic_en(cordic_en),
        .cordic_x0(cordic_x0), .cordic_y0(cordic_y0), .cordic_z0(cordic_z0),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Rotation-mode CORDIC, angle scaled so 32768 = pi.
    function automatic void cordic_ref(input longint xi, input longint yi, input longint zi,
                                       output logic signed [W:0] xo, output logic signed [W:0] yo,
                                       output logic signed [W-1:0] zo);
        longint x, y, z, xs, ys, a;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < W; i++) begin
            a  = longint'($rtoi($atan(1.0 / (2.0 ** i)) / 3.141592653589793 * 32768.0));
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - a;
            end else begin
                x = x + ys; y = y - xs; z = z + a;
            end
        end
        xo = x[W:0];
        yo = y[W:0];
        zo = z[W-1:0];
    endfunction

    // Behavioural CORDIC pipeline: compute on entry, then delay LAT enabled cycles.
    logic signed [W:0]   plx [LAT];
    logic signed [W:0]   ply [LAT];
    logic signed [W-1:0] plz [LAT];
    always @(posedge clk) begin
        logic signed [W:0]   tx, ty;
        logic signed [W-1:0] tz;
        if (cordic_en) begin
            cordic_ref(cordic_x0, cordic_y0, cordic_z0, tx, ty, tz);
            for (int i = LAT - 1; i > 0; i--) begin
                plx[i] <= plx[i-1];
                ply[i] <= ply[i-1];
                plz[i] <= plz[i-1];
            end
            plx[0] <= tx;
            ply[0] <= ty;
            plz[0] <= tz;
        end
    end
    assign cordic_x = plx[LAT-1];
    assign cordic_y = ply[LAT-1];
    assign cordic_z = plz[LAT-1];

    // Scoreboard: global issue-order queue with due time in enabled cycles.
    typedef struct {
        int                  tag;
        logic signed [W:0]   x;
        logic signed [W:0]   y;
        logic signed [W-1:0] z;
        int                  due;
    } exp_t;

    exp_t q[$];
    int   ecnt = 0;
    int   mptr = N - 1;
    int   stall_cnt = 0;
    int   acc_cnt [N];
    int   res_cnt [N];

    always @(negedge clk) begin
        bit           ov, en, found;
        int           g, t;
        logic [N-1:0] rr, rv;
        exp_t         e;
        if (reset) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cordic_en", cordic_en, 1);
            q.delete();
            mptr = N - 1;
        end else begin
            ov = (q.size() > 0) && (q[0].due == ecnt);
            t  = (q.size() > 0) ? q[0].tag : 0;
            en = !(ov && !rsp_ready[t]);
            found = 1'b0;
            g = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(mptr + k) % N]) begin
                    found = 1'b1;
                    g = (mptr + k) % N;
                end
            end
            rr = (found && en) ? (N'(1) << g) : '0;
            rv = ov ? (N'(1) << t) : '0;
            chk("cordic_en", cordic_en, en);
            chk("req_ready", req_ready, rr);
            chk("rsp_valid", rsp_valid, rv);
            chk("inflight", inflight, q.size());
            if (ov) begin
                chk("rsp_x", rsp_x, q[0].x);
                chk("rsp_y", rsp_y, q[0].y);
                chk("rsp_z", rsp_z, q[0].z);
            end
            if (found && en) begin
                chk("op_x0", cordic_x0, $signed(req_x[g*W +: W]));
                chk("op_y0", cordic_y0, $signed(req_y[g*W +: W]));
                chk("op_z0", cordic_z0, $signed(req_z[g*W +: W]));
            end else if (en) begin
                chk("bubble_ops", {cordic_x0, cordic_y0, cordic_z0}, 0);
            end
            if (!en) stall_cnt++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc_cnt[i]++;
                if (rsp_valid[i] && rsp_ready[i]) res_cnt[i]++;
            end
            if (ov && en) void'(q.pop_front());
            if (found && en) begin
                e.tag = g;
                cordic_ref($signed(req_x[g*W +: W]), $signed(req_y[g*W +: W]),
                           $signed(req_z[g*W +: W]), e.x, e.y, e.z);
                e.due = ecnt + LAT;
                q.push_back(e);
                mptr = g;
            end
            if (en) ecnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = W'($urandom);
            req_y[i*W +: W] = W'($urandom);
            req_z[i*W +: W] = W'($urandom);
        end
    endtask

    task automatic pulse_reset();
        step();
        reset = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            req_valid = '0;
            rand_ops();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W:0]   ex, ey;
        logic signed [W-1:0] ez;
        int n, bad;

        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        rand_ops();
        repeat (3) step();

        // Single request straight out of reset.
        reset = 1'b0;
        req_valid = 4'b0001;
        req_x[0 +: W] = 16'sd32767;
        req_y[0 +: W] = 16'sd0;
        req_z[0 +: W] = 16'sd16384;
        @(negedge clk);
        chk("single_accept", req_ready, 1);
        step();
        req_valid = '0;
        n = 1;
        while (rsp_valid[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        cordic_ref(32767, 0, 16384, ex, ey, ez);
        chk("single_latency", n, LAT);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_x", rsp_x, ex);
        chk("single_rsp_y", rsp_y, ey);
        chk("single_rsp_z", rsp_z, ez);
        step();
        chk("single_inflight_zero", inflight, 0);

        // Fairness: four requesters held active for 40 cycles.
        pulse_reset();
        for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; res_cnt[i] = 0; end
        for (int k = 0; k < 40; k++) begin
            req_valid = 4'hF;
            rand_ops();
            step();
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) chk($sformatf("fair_acc%0d", i), acc_cnt[i], 10);
        idle(25);
        for (int i = 0; i < N; i++) chk($sformatf("fair_res%0d", i), res_cnt[i], 10);

        // Backpressure on requester 2 while its result is at the output.
        step();
        req_valid = 4'b0100;
        rand_ops();
        n = 0;
        stall_cnt = 0;
        while (rsp_valid[2] !== 1'b1 && n < 60) begin
            step();
            req_valid = N'($urandom_range(0, 3));
            rand_ops();
            n++;
        end
        chk("bp_result_seen", rsp_valid[2], 1);
        rsp_ready[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            req_valid = N'($urandom_range(0, 3));
            rand_ops();
        end
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        chk("bp_stall_cycles", stall_cnt, 5);
        idle(25);
        chk("bp_drained", inflight, 0);

        // Continuous requests fill the pipeline.
        for (int k = 0; k < 40; k++) begin
            step();
            req_valid = 4'hF;
            rand_ops();
        end
        @(negedge clk);
        chk("full_inflight", inflight, LAT);
        chk("full_accept", |req_ready, 1);
        chk("full_result", |rsp_valid, 1);
        idle(25);

        // Reset with ten operations in flight.
        for (int k = 0; k < 10; k++) begin
            step();
            req_valid = 4'hF;
            rand_ops();
        end
        step();
        req_valid = '0;
        @(negedge clk);
        chk("midrst_inflight10", inflight, 10);
        pulse_reset();
        @(negedge clk);
        chk("midrst_inflight0", inflight, 0);
        bad = 0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) bad++;
        end
        chk("midrst_no_rsp", bad, 0);

        // Sparse traffic and pointer behaviour (pointer is at 3 after reset).
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("sparse_req1", req_ready, 4'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("sparse_bubble_x0", cordic_x0, 0);
        chk("sparse_bubble_z0", cordic_z0, 0);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("sparse_req3", req_ready, 4'b1000);
        step();
        req_valid = 4'b0011;
        @(negedge clk);
        chk("sparse_tie_after3", req_ready, 4'b0001);
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("sparse_req1_again", req_ready, 4'b0010);
        idle(25);

        // Random traffic with random result backpressure.
        for (int k = 0; k < 400; k++) begin
            step();
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            rand_ops();
        end
        step();
        req_valid = '0;
        rsp_ready = '1;
        idle(60);
        chk("final_queue_empty", q.size(), 0);
        chk("final_inflight", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter WIDTH, default 16: CORDIC input data width in bits.
REQ-002 Parameter LATENCY, default 19: cycles from a CORDIC input sample with en=1 to its result, counted in enabled cycles; must be ≥ 1.
REQ-003 Parameter NREQ, default 4: number of requesters; must be ≥ 2.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 req_valid  in  NREQ: per-requester operation request.
REQ-007 req_ready  out  NREQ: per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_x, req_y, req_z  in  NREQ*WIDTH each: signed operands, requester i in bits [i*WIDTH +: WIDTH].
REQ-009 rsp_valid  out  NREQ: one-hot result strobe addressed to the originating requester.
REQ-010 rsp_ready  in  NREQ: per-requester result accept.
REQ-011 rsp_x, rsp_y  out  WIDTH+1 each, rsp_z  out  WIDTH: shared result bus, all signed.
REQ-012 cordic_en  out  1: clock enable to the CORDIC pipeline.
REQ-013 cordic_x0, cordic_y0, cordic_z0  out  WIDTH each: signed CORDIC operands.
REQ-014 cordic_x, cordic_y  in  WIDTH+1 each, cordic_z  in  WIDTH: signed CORDIC results.
REQ-015 inflight  out  $clog2(LATENCY+1): number of valid operations in the pipeline.

Function
REQ-016 The block keeps a LATENCY-deep shift register of {valid, tag}, with tag $clog2(NREQ) bits wide, that mirrors the CORDIC pipeline and shifts only when cordic_en=1.
REQ-017 Output stage: out_valid = valid[LATENCY-1] and out_tag = tag[LATENCY-1].
REQ-018 cordic_en = !(out_valid && !rsp_ready[out_tag]): a result that is not accepted stalls the whole pipeline, and no result is dropped or reordered.
REQ-019 rsp_valid[i] = out_valid && (out_tag == i); rsp_x, rsp_y and rsp_z pass cordic_x, cordic_y and cordic_z through combinationally.
REQ-020 Arbitration is round-robin: grant goes to the first i with req_valid[i]=1, searching from ptr+1 modulo NREQ.
REQ-021 req_ready[i] = grant[i] && cordic_en; at most one requester is ready in any cycle.
REQ-022 req_ready depends combinationally on rsp_ready, and requesters must not make req_valid depend on req_ready.
REQ-023 On an accepted transfer, ptr <= the granted index, stage 0 is loaded with {1, granted index}, and cordic_x0, cordic_y0 and cordic_z0 carry that requester's operands in the same cycle.
REQ-024 When cordic_en=1 with no transfer, stage 0 is loaded with {0, x}; cordic_x0, cordic_y0 and cordic_z0 are driven to 0 and ptr holds.
REQ-025 When cordic_en=0, no transfer occurs, ptr and the shift register hold, and cordic operands are don't-care.
REQ-026 inflight = population count of valid[0..LATENCY-1], maintained as a counter: +1 on accept, -1 when an output is consumed, unchanged when both or neither occur.
REQ-027 inflight never exceeds LATENCY and never underflows.
REQ-028 Requester operands must be stable only during the transfer cycle; results are not buffered inside the block.
REQ-029 Back-to-back accepts from one requester are allowed when only that requester is requesting.
REQ-030 Results for each requester return in issue order, exactly LATENCY enabled cycles after accept.

Reset
REQ-031 While reset=1, all valid bits clear, ptr <= NREQ-1 (requester 0 has first priority), and inflight <= 0.
REQ-032 While reset=1, rsp_valid=0, req_ready=0 and cordic_en=1.
REQ-033 Reset asserted mid-operation discards all in-flight operations; no rsp_valid is produced for them after reset deasserts.
REQ-034 First accept is possible in the cycle after reset deasserts.

Verification
REQ-035 Single requester: NREQ=4; req 0 issues x=32767, y=0, z=16384 once; rsp_ready all 1 -> rsp_valid=4'b0001 exactly 19 cycles after the accept, rsp data equals a reference cordic model, inflight returns to 0.
REQ-036 Fairness: all four req_valid held high for 40 cycles -> grants follow 0,1,2,3,0,...; each requester receives 10 accepts and 10 results in order.
REQ-037 Backpressure: rsp_ready[2] low for 5 cycles while its result is at the output -> cordic_en=0 for those 5 cycles, req_ready all 0, no results lost, every later result delayed by 5 cycles.
REQ-038 Full pipeline: continuous requests -> inflight saturates at 19 and stays there with one accept and one result per cycle.
REQ-039 Reset mid-flight: 10 operations in flight, reset pulsed for 1 cycle -> inflight=0 and no rsp_valid in the following 19 cycles without new requests.
REQ-040 Sparse traffic: req 3 only, then req 1 only -> ptr is respected (after a grant to 3, requester 0 would win a tie), bubble cycles drive cordic operands to 0.
